alu_dispatch_sched: RTL and testbench

- Sits between rename/ROB allocation and the bank of ALU issue queues (IQs).
- Each cycle it takes up to DISPATCH_CNT in-order instructions and steers each one to a distinct ALU IQ. It drives each IQ's per-slot choose vector and back-pressures upstream.
- It keeps a per-IQ credit counter of free entries and rotates IQ priority round-robin so load spreads evenly across the IQs.

---
 rtl/alu_dispatch_sched_pkg.sv | 14 +
 rtl/alu_dispatch_sched_if.sv | 28 ++
 rtl/alu_dispatch_sched_iq_credit_cnt.sv | 35 +++
 rtl/alu_dispatch_sched.sv | 107 ++++++++++
 tb/tb_alu_dispatch_sched.sv | 123 ++++++++++++
 5 files changed

// File: rtl/alu_dispatch_sched_pkg.sv
// Shared constants and types for the ALU dispatch scheduler slice.
package alu_dispatch_sched_pkg;

    localparam int ALU_IQ_CNT   = 2;
    localparam int IQ_SIZE      = 4;
    localparam int DISPATCH_CNT = 2;

    localparam int CREDIT_W = $clog2(IQ_SIZE + 1);
    localparam int IQ_IDX_W = (ALU_IQ_CNT > 1) ? $clog2(ALU_IQ_CNT) : 1;

    typedef logic [CREDIT_W-1:0] iq_credit_t;
    typedef logic [IQ_IDX_W-1:0] iq_idx_t;

endpackage

// File: rtl/alu_dispatch_sched_if.sv
// Dispatch-side bundle: upstream slots, per-IQ choose/valid, issue returns, credit debug.
interface alu_dispatch_sched_if
    import alu_dispatch_sched_pkg::*;
#(
    parameter int IQ_CNT    = ALU_IQ_CNT,
    parameter int SLOT_CNT  = DISPATCH_CNT,
    parameter int CREDIT_WD = CREDIT_W
);
    logic                                 flush;
    logic [SLOT_CNT-1:0]                  slot_valid_i;
    logic [SLOT_CNT-1:0]                  slot_accept_o;
    logic [IQ_CNT-1:0][SLOT_CNT-1:0]      iq_choose_o;
    logic [IQ_CNT-1:0]                    iq_valid_o;
    logic [IQ_CNT-1:0]                    iq_issue_i;
    logic [IQ_CNT-1:0][CREDIT_WD-1:0]     credit_o;

    // Upstream / environment side.
    modport master (
        output flush, slot_valid_i, iq_issue_i,
        input  slot_accept_o, iq_choose_o, iq_valid_o, credit_o
    );

    // Scheduler side.
    modport slave (
        input  flush, slot_valid_i, iq_issue_i,
        output slot_accept_o, iq_choose_o, iq_valid_o, credit_o
    );
endinterface

// File: rtl/alu_dispatch_sched_iq_credit_cnt.sv
// Free-entry counter for one IQ: preloads to IQ_SIZE on reset/flush, saturates at IQ_SIZE.
module iq_credit_cnt #(
    parameter int IQ_SIZE  = 4,
    parameter int CREDIT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                dec,
    input  logic                inc,
    output logic [CREDIT_W-1:0] credit
);
    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(IQ_SIZE);

    logic [CREDIT_W-1:0] credit_q;

    assign credit = credit_q;

    // Credit register: dispatch consumes an entry, issue returns one; flush drops in-flight issues.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            credit_q <= FULL;
        end else if (inc && !dec && credit_q == FULL) begin
            credit_q <= FULL;
        end else begin
            credit_q <= credit_q - CREDIT_W'(dec) + CREDIT_W'(inc);
        end
    end

    // An IQ holding IQ_SIZE free entries is empty, so it has nothing to issue.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || flush)
                                    !(inc && credit_q == FULL))
        else $error("iq_credit_cnt: issue returned while credit already at IQ_SIZE");

endmodule

// File: rtl/alu_dispatch_sched.sv
// Steers up to DISPATCH_CNT in-order slots to distinct ALU IQs with rotating priority and credits.
module alu_dispatch_sched #(
    parameter int IQ_CNT       = alu_dispatch_sched_pkg::ALU_IQ_CNT,
    parameter int IQ_SIZE      = alu_dispatch_sched_pkg::IQ_SIZE,
    parameter int DISPATCH_CNT = alu_dispatch_sched_pkg::DISPATCH_CNT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_dispatch_sched_if.slave  bus
);
    import alu_dispatch_sched_pkg::*;

    localparam int CREDIT_WL = $clog2(IQ_SIZE + 1);
    localparam int IDX_W     = (IQ_CNT > 1) ? $clog2(IQ_CNT) : 1;

    logic [IQ_CNT-1:0][CREDIT_WL-1:0]    credit_q;
    logic [IDX_W-1:0]                    rr_ptr_q;
    logic [IDX_W-1:0]                    rr_ptr_d;
    logic [DISPATCH_CNT-1:0]             accept;
    logic [IQ_CNT-1:0][DISPATCH_CNT-1:0] choose;
    logic [IQ_CNT-1:0]                   iq_valid;
    logic [IQ_CNT-1:0]                   taken;
    logic                                hold;
    logic                                found;
    logic                                blocked;
    int                                  idx;
    int                                  sel;
    int                                  last_iq;

    // Reset and flush both blank the outputs in the same cycle they are seen.
    assign hold = !rst_n || bus.flush;

    // Rotating-priority allocator: each slot takes the first eligible, not-yet-taken IQ from rr_ptr.
    always_comb begin
        accept  = '0;
        choose  = '0;
        taken   = '0;
        blocked = 1'b0;
        found   = 1'b0;
        idx     = 0;
        sel     = 0;
        last_iq = 0;
        for (int k = 0; k < DISPATCH_CNT; k++) begin
            found = 1'b0;
            sel   = 0;
            for (int off = 0; off < IQ_CNT; off++) begin
                idx = (int'(rr_ptr_q) + off) % IQ_CNT;
                if (!found && credit_q[idx] != '0 && !taken[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
            if (!hold && !blocked && bus.slot_valid_i[k] && found) begin
                accept[k]       = 1'b1;
                choose[sel][k]  = 1'b1;
                taken[sel]      = 1'b1;
                last_iq         = sel;
            end else begin
                blocked = 1'b1;
            end
        end
    end

    // Per-IQ valid is simply whether any slot was steered to it.
    always_comb begin
        for (int q = 0; q < IQ_CNT; q++) begin
            iq_valid[q] = |choose[q];
        end
    end

    // Priority moves past the IQ that took the youngest accepted slot.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|accept) begin
            rr_ptr_d = IDX_W'((last_iq + 1) % IQ_CNT);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (hold) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar q = 0; q < IQ_CNT; q++) begin : g_credit
        iq_credit_cnt #(
            .IQ_SIZE  (IQ_SIZE),
            .CREDIT_W (CREDIT_WL)
        ) u_credit (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (bus.flush),
            .dec    (iq_valid[q]),
            .inc    (bus.iq_issue_i[q]),
            .credit (credit_q[q])
        );
    end

    assign bus.slot_accept_o = accept;
    assign bus.iq_choose_o   = choose;
    assign bus.iq_valid_o    = iq_valid;
    assign bus.credit_o      = credit_q;

endmodule

// File: tb/tb_alu_dispatch_sched.sv
// Directed-vector bench with a queue scoreboard for alu_dispatch_sched.
module tb_alu_dispatch_sched;

    typedef struct {
        string      name;
        logic [1:0] acc;
        logic [1:0] ch0;
        logic [1:0] ch1;
        logic [2:0] c0;
        logic [2:0] c1;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    alu_dispatch_sched_if dif ();

    alu_dispatch_sched u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, want);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected during that cycle.
    task automatic step(input string nm, input logic rn, input logic fl,
                        input logic [1:0] v, input logic [1:0] iss,
                        input logic [1:0] acc, input logic [1:0] ch0, input logic [1:0] ch1,
                        input int c0, input int c1);
        exp_t e;
        rst_n            = rn;
        dif.flush        = fl;
        dif.slot_valid_i = v;
        dif.iq_issue_i   = iss;
        e.name = nm;
        e.acc  = acc;
        e.ch0  = ch0;
        e.ch1  = ch1;
        e.c0   = 3'(c0);
        e.c1   = 3'(c1);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so every mid-cycle sample is a response.
    initial begin
        exp_t e;
        logic [1:0] vwant;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vwant = {|e.ch1, |e.ch0};
                chk(e.name, "accept",  8'(dif.slot_accept_o),  8'(e.acc));
                chk(e.name, "choose0", 8'(dif.iq_choose_o[0]), 8'(e.ch0));
                chk(e.name, "choose1", 8'(dif.iq_choose_o[1]), 8'(e.ch1));
                chk(e.name, "iqvalid", 8'(dif.iq_valid_o),     8'(vwant));
                chk(e.name, "credit0", 8'(dif.credit_o[0]),    8'(e.c0));
                chk(e.name, "credit1", 8'(dif.credit_o[1]),    8'(e.c1));
            end
        end
    end

    initial begin
        total            = 0;
        bad              = 0;
        rst_n            = 1'b0;
        dif.flush        = 1'b0;
        dif.slot_valid_i = 2'b00;
        dif.iq_issue_i   = 2'b00;
        @(posedge clk);
        #1;
        //    name         rn    fl    valid  issue  accept ch0    ch1    c0 c1
        step("reset",     1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 4, 4);
        step("both",      1'b1, 1'b0, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 4, 4);
        step("s0only",    1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 3, 3);
        step("rotated",   1'b1, 1'b0, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2, 3);
        step("ptr1",      1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 1, 2);
        step("ptr0",      1'b1, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 1, 1);
        step("iss1a",     1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1);
        step("iss1b",     1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 2);
        step("iss1c",     1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 3);
        step("iq0empty",  1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 0, 4);
        step("drain3",    1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 0, 3);
        step("drain2",    1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 0, 2);
        step("drain1",    1'b1, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 0, 1);
        step("allzero",   1'b1, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 0, 0);
        step("refill",    1'b1, 1'b0, 2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 1, 0);
        step("hole",      1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 0);
        step("wrap",      1'b1, 1'b0, 2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 1, 1);
        step("iss11",     1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1);
        step("flush",     1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1, 2);
        step("postflush", 1'b1, 1'b0, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 4, 4);
        step("ret",       1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 3, 3);
        step("idle",      1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 4, 4);
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
